sobel_frame_ctrl: RTL and testbench

- Frame sequencer between the image block RAMs and the Sobel datapath.
- On start, raster-scans the input image memory and presents pixels to the Sobel core as a valid/ready stream, with start-of-frame and end-of-line markers.
- Writes the core's result stream to the output image memory at sequential addresses and signals completion.
- Owns all address generation for both memories. Both memories have 1-cycle synchronous read latency.

---
 rtl/sobel_frame_ctrl_pkg.sv | 19 +
 rtl/sobel_skid_fifo.sv | 49 ++++
 rtl/sobel_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_frame_ctrl_pkg.sv
// Shared configuration for the Sobel frame sequencer:
// memory geometry, image geometry and frame FSM states.
package mem_config_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 8;
endpackage

package sobel_config_pkg;
    localparam int IMG_W = 256;
    localparam int IMG_H = 256;
    localparam int NPIX  = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } frame_state_e;
endpackage

// File: rtl/sobel_skid_fifo.sv
// Two-entry skid FIFO carrying {sof, eol, data} pixel beats.
// Simultaneous push and pop are both honoured, even when full.
module sobel_skid_fifo #(
    parameter int WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;
endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: raster-scans the input RAM into the Sobel core
// and writes the result stream to the output RAM.
module sobel_frame_ctrl #(
    parameter int ADDR_WIDTH = mem_config_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = mem_config_pkg::DATA_WIDTH,
    parameter int IMG_W      = sobel_config_pkg::IMG_W,
    parameter int IMG_H      = sobel_config_pkg::IMG_H
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  in_wr_en_o,
    output logic [ADDR_WIDTH-1:0] in_addr_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic [DATA_WIDTH-1:0] pix_data_o,
    output logic                  pix_sof_o,
    output logic                  pix_eol_o,
    input  logic                  res_valid_i,
    input  logic [DATA_WIDTH-1:0] res_data_i,
    output logic                  out_wr_en_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = ADDR_WIDTH + 1;
    localparam int FW   = DATA_WIDTH + 2;

    import sobel_config_pkg::*;

    if (IMG_W < 1 || IMG_H < 1 ||
        longint'(NPIX) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_geom
        $error("sobel_frame_ctrl: frame does not fit address space");
    end

    frame_state_e          state_q, state_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]         col_q, col_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  inflight_q;
    logic                  sof_q, sof_d;
    logic                  issue;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  fifo_full, fifo_empty, pop;
    logic [1:0]            fifo_cnt;
    logic [2:0]            occ;
    logic [FW-1:0]         fifo_din, fifo_dout;

    // Room is judged after this cycle's pop so a full-rate stream never bubbles
    assign pop      = !fifo_empty && pix_ready_i;
    assign occ      = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    assign fifo_din = {sof_q, col_q == CW'(IMG_W - 1), in_data_i};

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        col_d    = col_q;
        issue    = 1'b0;
        sof_d    = 1'b0;
        wr_en_d  = res_valid_i && (state_q == FETCH || state_q == DRAIN) &&
                   (wr_cnt_q != CW'(NPIX));
        if (wr_en_d) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
        end
        if (inflight_q) begin
            col_d = (col_q == CW'(IMG_W - 1)) ? '0 : col_q + CW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    issue    = 1'b1;
                    sof_d    = 1'b1;
                    rd_cnt_d = CW'(1);
                    wr_cnt_d = '0;
                    col_d    = '0;
                    state_d  = (NPIX == 1) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (occ < 3'd2 && !(fifo_full && !pop)) begin
                    issue    = 1'b1;
                    rd_cnt_d = rd_cnt_q + CW'(1);
                    if (rd_cnt_q == CW'(NPIX - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (wr_cnt_q == CW'(NPIX)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address 0 goes out in the start cycle itself to save a cycle of latency
    assign in_addr_o = !issue ? addr_q :
                       (state_q == IDLE) ? '0 : rd_cnt_q[ADDR_WIDTH-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            sof_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            col_q      <= col_d;
            addr_q     <= in_addr_o;
            inflight_q <= issue;
            sof_q      <= sof_d;
            wr_en_q    <= wr_en_d;
            if (wr_en_d) begin
                wr_addr_q <= wr_cnt_q[ADDR_WIDTH-1:0];
                wr_data_q <= res_data_i;
            end
        end
    end

    sobel_skid_fifo #(
        .WIDTH(FW)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (inflight_q),
        .pop_i  (pop),
        .din_i  (fifo_din),
        .dout_o (fifo_dout),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_cnt)
    );

    assign busy_o      = (state_q == FETCH) || (state_q == DRAIN);
    assign done_o      = (state_q == DONE);
    assign in_wr_en_o  = 1'b0;
    assign pix_valid_o = !fifo_empty;
    assign pix_sof_o   = fifo_dout[FW-1];
    assign pix_eol_o   = fifo_dout[FW-2];
    assign pix_data_o  = fifo_dout[DATA_WIDTH-1:0];
    assign out_wr_en_o = wr_en_q;
    assign out_addr_o  = wr_addr_q;
    assign out_data_o  = wr_data_q;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: 4x3 frames with a looped-back core
// model under varied backpressure, plus a 1x1 frame.
module tb_sobel_frame_ctrl;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start_a, busy_a, done_a, in_we_a;
    logic [AW-1:0] in_addr_a;
    logic [DW-1:0] in_data_a;
    logic          pv_a, pr_a, sof_a, eol_a;
    logic [DW-1:0] pd_a;
    logic          rv_a;
    logic [DW-1:0] rd_a;
    logic          we_a;
    logic [AW-1:0] oa_a;
    logic [DW-1:0] od_a;

    logic          start_b, busy_b, done_b, in_we_b;
    logic [AW-1:0] in_addr_b;
    logic [DW-1:0] in_data_b;
    logic          pv_b, pr_b, sof_b, eol_b;
    logic [DW-1:0] pd_b;
    logic          rv_b;
    logic [DW-1:0] rd_b;
    logic          we_b;
    logic [AW-1:0] oa_b;
    logic [DW-1:0] od_b;

    logic [DW-1:0] mem_a [N];
    logic [DW-1:0] mem_b;

    int n_chk = 0;
    int n_fail = 0;

    bit            dl_v [3];
    logic [DW-1:0] dl_d [3];

    sobel_frame_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a),
        .busy_o(busy_a), .done_o(done_a), .in_wr_en_o(in_we_a),
        .in_addr_o(in_addr_a), .in_data_i(in_data_a),
        .pix_valid_o(pv_a), .pix_ready_i(pr_a), .pix_data_o(pd_a),
        .pix_sof_o(sof_a), .pix_eol_o(eol_a),
        .res_valid_i(rv_a), .res_data_i(rd_a),
        .out_wr_en_o(we_a), .out_addr_o(oa_a), .out_data_o(od_a)
    );

    sobel_frame_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMG_W(1), .IMG_H(1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b),
        .busy_o(busy_b), .done_o(done_b), .in_wr_en_o(in_we_b),
        .in_addr_o(in_addr_b), .in_data_i(in_data_b),
        .pix_valid_o(pv_b), .pix_ready_i(pr_b), .pix_data_o(pd_b),
        .pix_sof_o(sof_b), .pix_eol_o(eol_b),
        .res_valid_i(rv_b), .res_data_i(rd_b),
        .out_wr_en_o(we_b), .out_addr_o(oa_b), .out_data_o(od_b)
    );

    // Synchronous-read memories, one cycle latency
    always @(posedge clk) begin
        in_data_a <= (int'(in_addr_a) < N) ? mem_a[in_addr_a] : 8'hXX;
        in_data_b <= mem_b;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy_a, done_a, pv_a, we_a, in_we_a} !== 5'b0 ||
            in_addr_a !== '0 || oa_a !== '0 || od_a !== '0) begin
            n_fail++;
            $display("FAIL reset_a: busy=%b done=%b pv=%b we=%b ia=%0d oa=%0d od=%0d, want all 0",
                     busy_a, done_a, pv_a, we_a, in_addr_a, oa_a, od_a);
        end
        n_chk++;
        if ({busy_b, done_b, pv_b, we_b} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_b: busy=%b done=%b pv=%b we=%b, want 0",
                     busy_b, done_b, pv_b, we_b);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 random ready
    task automatic run_frame(input string nm, input int mode,
                             input bit restart, input int extras,
                             input int abort_at);
        int acc, wr, dones, emitted, xleft, first_v, cyc;
        bit st_prev, restarted, fin, acc_now;
        logic [DW+1:0] prev;
        for (int i = 0; i < N; i++) mem_a[i] = DW'($urandom);
        for (int k = 0; k < 3; k++) dl_v[k] = 1'b0;
        acc = 0; wr = 0; dones = 0; emitted = 0; xleft = extras;
        first_v = -1; cyc = 0; st_prev = 0; restarted = 0; fin = 0;
        prev = '0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            start_a = (cyc == 0) || (restart && cyc == 6);
            if (restart && acc == N && !restarted) begin
                start_a = 1'b1;
                restarted = 1'b1;
            end
            case (mode)
                0: pr_a = 1'b1;
                1: pr_a = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: pr_a = 1'($urandom % 2);
            endcase
            if (dl_v[2]) begin
                rv_a = 1'b1; rd_a = dl_d[2]; emitted++;
            end else if (emitted >= N && xleft > 0) begin
                rv_a = 1'b1; rd_a = 8'hEE; xleft--; emitted++;
            end else begin
                rv_a = 1'b0; rd_a = '0;
            end
            #1;
            if (st_prev) begin
                n_chk++;
                if (pv_a !== 1'b1 || {sof_a, eol_a, pd_a} !== prev) begin
                    n_fail++;
                    $display("FAIL %s stall_hold: v=%b beat=%h, want v=1 beat=%h",
                             nm, pv_a, {sof_a, eol_a, pd_a}, prev);
                end
            end
            if (busy_a) begin
                n_chk++;
                if (int'(in_addr_a) > acc + 2) begin
                    n_fail++;
                    $display("FAIL %s read_lead: in_addr=%0d, want <= %0d",
                             nm, in_addr_a, acc + 2);
                end
            end
            if (pv_a === 1'b1 && first_v < 0) begin
                first_v = cyc;
                n_chk++;
                if (cyc != 2) begin
                    n_fail++;
                    $display("FAIL %s first_valid: cycle %0d, want 2", nm, cyc);
                end
            end
            acc_now = (pv_a === 1'b1) && pr_a;
            if (acc_now) begin
                n_chk++;
                if (acc >= N || pd_a !== mem_a[acc] ||
                    sof_a !== (acc == 0) || eol_a !== (acc % W == W - 1)) begin
                    n_fail++;
                    $display("FAIL %s pixel %0d: d=%h sof=%b eol=%b, want d=%h sof=%b eol=%b",
                             nm, acc, pd_a, sof_a, eol_a,
                             (acc < N) ? mem_a[acc] : 8'h00,
                             acc == 0, acc % W == W - 1);
                end
                acc++;
            end
            st_prev = (pv_a === 1'b1) && !pr_a;
            prev = {sof_a, eol_a, pd_a};
            if (we_a === 1'b1) begin
                n_chk++;
                if (wr >= N || int'(oa_a) != wr || od_a !== mem_a[wr]) begin
                    n_fail++;
                    $display("FAIL %s write %0d: addr=%0d data=%h, want addr=%0d data=%h",
                             nm, wr, oa_a, od_a, wr, (wr < N) ? mem_a[wr] : 8'h00);
                end
                wr++;
            end
            if (done_a === 1'b1) begin
                dones++;
                n_chk++;
                if (busy_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s busy_at_done: busy=%b, want 0", nm, busy_a);
                end
            end else if (dones > 0) begin
                fin = 1'b1;
            end
            if (abort_at > 0 && acc == abort_at) begin
                #1 rst_n = 1'b0;
                #1;
                n_chk++;
                if ({busy_a, done_a, pv_a, we_a} !== 4'b0 ||
                    in_addr_a !== '0 || oa_a !== '0 || od_a !== '0) begin
                    n_fail++;
                    $display("FAIL %s abort: busy=%b done=%b pv=%b we=%b ia=%0d oa=%0d od=%0d, want 0",
                             nm, busy_a, done_a, pv_a, we_a, in_addr_a, oa_a, od_a);
                end
                start_a = 1'b0; rv_a = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    n_chk++;
                    if (we_a !== 1'b0 || busy_a !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s post_abort: we=%b busy=%b, want 0 0",
                                 nm, we_a, busy_a);
                    end
                end
                return;
            end
            dl_v[2] = dl_v[1]; dl_d[2] = dl_d[1];
            dl_v[1] = dl_v[0]; dl_d[1] = dl_d[0];
            dl_v[0] = acc_now; dl_d[0] = pd_a;
            cyc++;
        end
        start_a = 1'b0;
        n_chk++;
        if (!fin) begin
            n_fail++;
            $display("FAIL %s timeout: done not seen after %0d cycles, want done", nm, cyc);
        end
        n_chk++;
        if (acc != N || wr != N || dones != 1) begin
            n_fail++;
            $display("FAIL %s totals: pix=%0d writes=%0d dones=%0d, want %0d %0d 1",
                     nm, acc, wr, dones, N, N);
        end
        // A result offered while idle must not be written
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            rv_a = (t == 0); rd_a = 8'h5A;
            #1;
            n_chk++;
            if (we_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle: we=%b busy=%b done=%b, want 0 0 0",
                         nm, we_a, busy_a, done_a);
            end
        end
        rv_a = 1'b0;
    endtask

    task automatic test_single_pixel();
        int acc, wr, dones;
        bit pend;
        logic [DW-1:0] pend_d;
        mem_b = DW'($urandom);
        acc = 0; wr = 0; dones = 0; pend = 0; pend_d = '0;
        pr_b = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            start_b = (cyc == 0);
            rv_b = pend; rd_b = pend_d;
            #1;
            pend = (pv_b === 1'b1);
            pend_d = pd_b;
            if (pv_b === 1'b1) begin
                n_chk++;
                if (pd_b !== mem_b || sof_b !== 1'b1 || eol_b !== 1'b1) begin
                    n_fail++;
                    $display("FAIL px1 pixel: d=%h sof=%b eol=%b, want d=%h sof=1 eol=1",
                             pd_b, sof_b, eol_b, mem_b);
                end
                acc++;
            end
            if (we_b === 1'b1) begin
                n_chk++;
                if (oa_b !== '0 || od_b !== mem_b) begin
                    n_fail++;
                    $display("FAIL px1 write: addr=%0d data=%h, want 0 %h",
                             oa_b, od_b, mem_b);
                end
                wr++;
            end
            if (done_b === 1'b1) dones++;
        end
        start_b = 1'b0; rv_b = 1'b0;
        n_chk++;
        if (acc != 1 || wr != 1 || dones != 1 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL px1 totals: pix=%0d writes=%0d dones=%0d busy=%b, want 1 1 1 0",
                     acc, wr, dones, busy_b);
        end
    endtask

    initial begin
        start_a = 0; pr_a = 0; rv_a = 0; rd_a = '0;
        start_b = 0; pr_b = 0; rv_b = 0; rd_b = '0;
        mem_b = '0;
        for (int i = 0; i < N; i++) mem_a[i] = '0;
        test_reset();
        run_frame("full_rate", 0, 1'b0, 0, 0);
        run_frame("stall_1001", 1, 1'b0, 0, 0);
        run_frame("restart_ignored", 0, 1'b1, 0, 0);
        run_frame("extra_results", 0, 1'b0, 2, 0);
        run_frame("random_ready", 2, 1'b0, 0, 0);
        run_frame("abort", 2, 1'b0, 0, 5);
        run_frame("after_abort", 0, 1'b0, 0, 0);
        test_single_pixel();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
